// File: rtl/mat_pipeline_ctrl.sv
// rtl/mat_pipeline_ctrl.sv - packet sequencer: parser then up to NUM_STAGES match/exec stages (optional watchdog: PROC_TIMEOUT_EN)
module mat_pipeline_ctrl #(
  parameter  int NUM_STAGES     = 4,
  parameter  int AW             = 32,
  parameter  int DW             = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int SW             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int MREQ_W         = 2 + AW + 4 + DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              cfg_we_i,
  input  logic [SW-1:0]     cfg_stage_i,
  input  logic              cfg_en_i,
  input  logic [AW-1:0]     cfg_hit_addr_i,
  input  logic [AW-1:0]     cfg_miss_addr_i,
  output logic              ps_start_o,
  input  logic              ps_ready_i,
  output logic              mt_start_o,
  input  logic              mt_ready_i,
  input  logic [AW-1:0]     mt_val_addr_i,
  output logic              ex_start_o,
  input  logic              ex_ready_i,
  output logic [AW-1:0]     ex_start_addr_o,
  output logic [AW-1:0]     ex_args_addr_o,
  output logic [SW-1:0]     stage_o,
  input  logic [MREQ_W-1:0] ps_mreq_i,
  input  logic [MREQ_W-1:0] mt_mreq_i,
  input  logic [MREQ_W-1:0] ex_mreq_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DW-1:0]     mem_data_o
);

  typedef enum logic [2:0] {S_IDLE, S_PARSE, S_MATCH, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {SEL_PS, SEL_MT, SEL_EX} sel_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state, state_nx;
  sel_t                  sel;
  logic [NUM_STAGES-1:0] stage_en;
  logic [AW-1:0]         hit_tbl  [NUM_STAGES];
  logic [AW-1:0]         miss_tbl [NUM_STAGES];
  logic [SW-1:0]         stage, first_idx, next_idx;
  logic                  first_ok, next_ok;
  logic [AW-1:0]         ex_addr, args_addr;
  logic                  cfg_ok;
  logic                  timeout;
  logic [MREQ_W-1:0]     mreq_sel;

  // Out-of-range indices are dropped so they cannot alias onto a real stage.
  assign cfg_ok = cfg_we_i && (32'(cfg_stage_i) < NUM_STAGES);

  // Stage config table: written only while idle, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_en <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        hit_tbl[i]  <= '0;
        miss_tbl[i] <= '0;
      end
    end else if (state == S_IDLE && cfg_ok) begin
      stage_en[cfg_stage_i] <= cfg_en_i;
      hit_tbl[cfg_stage_i]  <= cfg_hit_addr_i;
      miss_tbl[cfg_stage_i] <= cfg_miss_addr_i;
    end
  end

  // Find the lowest enabled stage and the lowest enabled stage above the current one.
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_en[i]) begin
        first_ok  = 1'b1;
        first_idx = SW'(i);
        if (SW'(i) > stage) begin
          next_ok  = 1'b1;
          next_idx = SW'(i);
        end
      end
    end
  end

`ifdef PROC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          err;
  logic          waiting;

  // A wait state times out on its last allowed cycle unless the ready shows up in it.
  always_comb begin
    waiting = (state == S_PARSE && !ps_ready_i) ||
              (state == S_MATCH && !mt_ready_i) ||
              (state == S_EXEC  && !ex_ready_i);
    timeout = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  end

  // Per-wait-state cycle counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst || state_nx != state || state == S_IDLE || state == S_DONE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Error flag lives from the abort until the requester releases start_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (state == S_DONE && !start_i) begin
      err <= 1'b0;
    end
  end

  assign err_o = err;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // State register plus the datapath registers that change on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= SEL_PS;
      stage     <= '0;
      ex_addr   <= '0;
      args_addr <= '0;
    end else begin
      state <= state_nx;
      case (state_nx)
        S_MATCH: sel <= SEL_MT;
        S_EXEC:  sel <= SEL_EX;
        default: sel <= SEL_PS;
      endcase
      if (state == S_PARSE && state_nx == S_MATCH) stage <= first_idx;
      if (state == S_EXEC && state_nx == S_MATCH) stage <= next_idx;
      if (state == S_MATCH && mt_ready_i) begin
        ex_addr   <= (mt_val_addr_i != '0) ? hit_tbl[stage] : miss_tbl[stage];
        args_addr <= mt_val_addr_i;
      end
    end
  end

  // Next-state logic; a config write in IDLE pushes a pending start back one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!cfg_we_i && start_i) state_nx = S_PARSE;
      S_PARSE: if (ps_ready_i) state_nx = first_ok ? S_MATCH : S_DONE;
      S_MATCH: if (mt_ready_i) state_nx = S_EXEC;
      S_EXEC:  if (ex_ready_i) state_nx = next_ok ? S_MATCH : S_DONE;
      S_DONE:  if (!start_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (timeout) state_nx = S_DONE;
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    ps_start_o      = (state == S_PARSE);
    mt_start_o      = (state == S_MATCH);
    ex_start_o      = (state == S_EXEC);
    ready_o         = (state == S_DONE);
    busy_o          = (state == S_PARSE) || (state == S_MATCH) || (state == S_EXEC);
    stage_o         = stage;
    ex_start_addr_o = ex_addr;
    ex_args_addr_o  = args_addr;
  end

  // Memory bus follows the registered owner select.
  always_comb begin
    mreq_sel = ps_mreq_i;
    case (sel)
      SEL_MT:  mreq_sel = mt_mreq_i;
      SEL_EX:  mreq_sel = ex_mreq_i;
      default: mreq_sel = ps_mreq_i;
    endcase
  end

  assign {mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o} = mreq_sel;

endmodule
